// File: rtl/bcd_digit_accumulator_pkg.sv
// rtl/bcd_digit_accumulator_pkg.sv - shared state encodings, constants and digit picker for the BCD accumulator
package bcd_digit_accumulator_pkg;

  typedef enum logic {
    ENTRY = 1'b0,
    CONV  = 1'b1
  } state_t;

  localparam logic [3:0] BCD_MAX_CODE  = 4'd9;
  localparam logic [3:0] BCD_BACKSPACE = 4'hA;
  localparam int         BCD_ACC_W     = 10;
  localparam int         DIGITS_W      = 12;

  // Digit 0 is the most recently entered one; higher slots are older.
  function automatic logic [3:0] pick_digit(input logic [DIGITS_W-1:0] digits,
                                            input logic [1:0]          sel);
    case (sel)
      2'd0:    pick_digit = digits[3:0];
      2'd1:    pick_digit = digits[7:4];
      default: pick_digit = digits[11:8];
    endcase
  endfunction

endpackage

// File: rtl/bcd_mac10.sv
// rtl/bcd_mac10.sv - combinational acc*10 + digit using shifts and adds
module bcd_mac10
  import bcd_digit_accumulator_pkg::*;
(
  input  logic [BCD_ACC_W-1:0] acc_in,
  input  logic [3:0]           digit,
  output logic [BCD_ACC_W-1:0] acc_out
);

  // acc*10 = acc*8 + acc*2; callers keep acc <= 99 so 10 bits never wrap.
  assign acc_out = (acc_in << 3) + (acc_in << 1) + {{(BCD_ACC_W-4){1'b0}}, digit};

endmodule

// File: rtl/bcd_digit_accumulator.sv
// rtl/bcd_digit_accumulator.sv - BCD digit entry and iterative decimal-to-binary conversion (option: BCD_ACC_BACKSPACE_EN)
module bcd_digit_accumulator
  import bcd_digit_accumulator_pkg::*;
#(
  parameter int MAX_DIGITS = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       digit_valid,
  input  logic [3:0] digit_in,
  output logic       digit_ready,
  input  logic       commit,
  input  logic       clear,
  output logic       busy,
  output logic [1:0] digit_count,
  output logic       result_valid,
  output logic [7:0] result,
  output logic       overflow,
  output logic       invalid_digit
);

  localparam logic [1:0] MAX_CNT = 2'(MAX_DIGITS);

  state_t                state, state_next;
  logic [1:0]            count, idx, cnt_in;
  logic [DIGITS_W-1:0]   digits, dig_in;
  logic [BCD_ACC_W-1:0]  acc, acc_next;
  logic                  accept, is_digit, is_bksp;
  logic                  start_conv, empty_commit, conv_done;

`ifdef BCD_ACC_BACKSPACE_EN
  // Backspace stays acceptable at full so the user can still correct the last digit.
  assign is_bksp     = (digit_in == BCD_BACKSPACE);
  assign digit_ready = (state == ENTRY) && ((count < MAX_CNT) || is_bksp);
`else
  assign is_bksp     = 1'b0;
  assign digit_ready = (state == ENTRY) && (count < MAX_CNT);
`endif

  assign is_digit    = (digit_in <= BCD_MAX_CODE);
  assign accept      = digit_valid && digit_ready;
  assign busy        = (state == CONV);
  assign digit_count = count;

  // Oldest stored digit first: slot count-1 down to slot 0.
  bcd_mac10 u_mac (
    .acc_in  (acc),
    .digit   (pick_digit(digits, count - 2'd1 - idx)),
    .acc_out (acc_next)
  );

  // Digit store contents after this cycle's handshake, so a digit taken with commit is converted too.
  always_comb begin
    cnt_in = count;
    dig_in = digits;
    if (accept && is_digit) begin
      cnt_in = count + 2'd1;
      dig_in = {digits[DIGITS_W-5:0], digit_in};
    end else if (accept && is_bksp && (count != 2'd0)) begin
      cnt_in = count - 2'd1;
      dig_in = {4'd0, digits[DIGITS_W-1:4]};
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= ENTRY;
    else        state <= state_next;
  end

  // Next-state decode; an empty commit answers immediately without entering CONV.
  always_comb begin
    state_next   = state;
    start_conv   = 1'b0;
    empty_commit = 1'b0;
    conv_done    = 1'b0;
    case (state)
      ENTRY: begin
        if (!clear && commit) begin
          if (cnt_in == 2'd0) begin
            empty_commit = 1'b1;
          end else begin
            start_conv = 1'b1;
            state_next = CONV;
          end
        end
      end
      CONV: begin
        if (clear) begin
          state_next = ENTRY;
        end else if (idx == count - 2'd1) begin
          conv_done  = 1'b1;
          state_next = ENTRY;
        end
      end
      default: state_next = ENTRY;
    endcase
  end

  // Digit store, accumulator and result registers; clear overrides any handshake or commit.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count         <= 2'd0;
      digits        <= '0;
      idx           <= 2'd0;
      acc           <= '0;
      result        <= 8'd0;
      overflow      <= 1'b0;
      result_valid  <= 1'b0;
      invalid_digit <= 1'b0;
    end else begin
      result_valid  <= 1'b0;
      invalid_digit <= 1'b0;
      if (clear) begin
        count  <= 2'd0;
        digits <= '0;
        idx    <= 2'd0;
        acc    <= '0;
      end else if (state == ENTRY) begin
        count  <= cnt_in;
        digits <= dig_in;
        if (accept && !is_digit && !is_bksp) invalid_digit <= 1'b1;
        if (start_conv) begin
          acc <= '0;
          idx <= 2'd0;
        end
        if (empty_commit) begin
          result_valid <= 1'b1;
          result       <= 8'd0;
          overflow     <= 1'b0;
          digits       <= '0;
        end
      end else begin
        acc <= acc_next;
        idx <= idx + 2'd1;
        if (conv_done) begin
          result_valid <= 1'b1;
          overflow     <= (acc_next > 10'd255);
          result       <= (acc_next > 10'd255) ? 8'hFF : acc_next[7:0];
          count        <= 2'd0;
          digits       <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_bcd_digit_accumulator.sv
// tb/tb_bcd_digit_accumulator.sv - self-checking bench for bcd_digit_accumulator
module tb_bcd_digit_accumulator;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       digit_valid;
  logic [3:0] digit_in;
  logic       digit_ready;
  logic       commit;
  logic       clear;
  logic       busy;
  logic [1:0] digit_count;
  logic       result_valid;
  logic [7:0] result;
  logic       overflow;
  logic       invalid_digit;

  int checks = 0;
  int errors = 0;

  logic [8:0] exp_q[$];

  typedef struct packed {
    logic [1:0] n;
    logic [3:0] d0;
    logic [3:0] d1;
    logic [3:0] d2;
    logic [7:0] r;
    logic       o;
  } vec_t;

  vec_t vecs[9];

  always #5 clk = ~clk;

  bcd_digit_accumulator #(.MAX_DIGITS(3)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .digit_valid   (digit_valid),
    .digit_in      (digit_in),
    .digit_ready   (digit_ready),
    .commit        (commit),
    .clear         (clear),
    .busy          (busy),
    .digit_count   (digit_count),
    .result_valid  (result_valid),
    .result        (result),
    .overflow      (overflow),
    .invalid_digit (invalid_digit)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && result_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_result_valid actual=1 required=0");
      end else begin
        logic [8:0] e;
        e = exp_q.pop_front();
        chk("result", {24'd0, result}, {24'd0, e[8:1]});
        chk("overflow", {31'd0, overflow}, {31'd0, e[0]});
      end
    end
  end

  task automatic send_digit(input logic [3:0] d);
    int n;
    n = 0;
    digit_valid = 1'b1;
    digit_in    = d;
    @(negedge clk);
    while (!digit_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!digit_ready) chk("send_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    digit_valid = 1'b0;
  endtask

  task automatic commit_expect(input int n, input logic [7:0] r, input logic o,
                               input logic dv, input logic [3:0] d);
    commit      = 1'b1;
    digit_valid = dv;
    digit_in    = d;
    exp_q.push_back({r, o});
    @(posedge clk);
    #1;
    commit      = 1'b0;
    digit_valid = 1'b0;
    for (int i = 1; i <= n; i++) begin
      @(negedge clk);
      chk("busy_conv", {31'd0, busy}, 32'd1);
      chk("rv_early", {31'd0, result_valid}, 32'd0);
    end
    @(negedge clk);
    chk("rv_latency", {31'd0, result_valid}, 32'd1);
    chk("busy_done", {31'd0, busy}, 32'd0);
    chk("count_after_result", {30'd0, digit_count}, 32'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{2'd3, 4'd2, 4'd5, 4'd5, 8'd255, 1'b0};
    vecs[1] = '{2'd3, 4'd2, 4'd5, 4'd6, 8'hFF,  1'b1};
    vecs[2] = '{2'd0, 4'd0, 4'd0, 4'd0, 8'd0,   1'b0};
    vecs[3] = '{2'd1, 4'd7, 4'd0, 4'd0, 8'd7,   1'b0};
    vecs[4] = '{2'd2, 4'd9, 4'd9, 4'd0, 8'd99,  1'b0};
    vecs[5] = '{2'd3, 4'd9, 4'd9, 4'd9, 8'hFF,  1'b1};
    vecs[6] = '{2'd3, 4'd1, 4'd0, 4'd0, 8'd100, 1'b0};
    vecs[7] = '{2'd2, 4'd0, 4'd5, 4'd0, 8'd5,   1'b0};
    vecs[8] = '{2'd3, 4'd1, 4'd2, 4'd8, 8'd128, 1'b0};

    rst_n = 1'b0; digit_valid = 1'b0; digit_in = 4'd0; commit = 1'b0; clear = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", {31'd0, digit_ready}, 32'd1);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_count", {30'd0, digit_count}, 32'd0);
    chk("rst_result", {24'd0, result}, 32'd0);
    chk("rst_overflow", {31'd0, overflow}, 32'd0);
    chk("rst_rv", {31'd0, result_valid}, 32'd0);
    chk("rst_invalid", {31'd0, invalid_digit}, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    for (int v = 0; v < 9; v++) begin
      logic [3:0] dd[3];
      dd[0] = vecs[v].d0; dd[1] = vecs[v].d1; dd[2] = vecs[v].d2;
      for (int j = 0; j < int'(vecs[v].n); j++) send_digit(dd[j]);
      @(negedge clk);
      chk("count_stored", {30'd0, digit_count}, {30'd0, vecs[v].n});
      @(posedge clk);
      #1;
      commit_expect(int'(vecs[v].n), vecs[v].r, vecs[v].o, 1'b0, 4'd0);
    end

    send_digit(4'd1); send_digit(4'd2); send_digit(4'd3);
    digit_valid = 1'b1; digit_in = 4'd9;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("full_ready", {31'd0, digit_ready}, 32'd0);
      chk("full_count", {30'd0, digit_count}, 32'd3);
    end
    @(posedge clk);
    #1;
    digit_valid = 1'b0;
    commit_expect(3, 8'd123, 1'b0, 1'b0, 4'd0);

    send_digit(4'd4);
    commit_expect(2, 8'd45, 1'b0, 1'b1, 4'd5);

    send_digit(4'd7); send_digit(4'd7);
    commit = 1'b1;
    @(posedge clk);
    #1;
    commit = 1'b0; clear = 1'b1;
    @(negedge clk);
    chk("clear_conv_busy", {31'd0, busy}, 32'd1);
    @(posedge clk);
    #1;
    clear = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("abort_busy", {31'd0, busy}, 32'd0);
      chk("abort_rv", {31'd0, result_valid}, 32'd0);
      chk("abort_count", {30'd0, digit_count}, 32'd0);
    end
    @(posedge clk);
    #1;

    send_digit(4'd7); send_digit(4'd7);
    commit = 1'b1;
    @(posedge clk);
    #1;
    commit = 1'b0; rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("reset_abort_busy", {31'd0, busy}, 32'd0);
      chk("reset_abort_rv", {31'd0, result_valid}, 32'd0);
      chk("reset_abort_count", {30'd0, digit_count}, 32'd0);
      chk("reset_result", {24'd0, result}, 32'd0);
    end
    @(posedge clk);
    #1;

    send_digit(4'd3);
    clear = 1'b1; digit_valid = 1'b1; digit_in = 4'd8;
    @(posedge clk);
    #1;
    clear = 1'b0; digit_valid = 1'b0;
    @(negedge clk);
    chk("clear_wins_count", {30'd0, digit_count}, 32'd0);
    @(posedge clk);
    #1;

    send_digit(4'd5);
    send_digit(4'hC);
    @(negedge clk);
    chk("invalid_pulse", {31'd0, invalid_digit}, 32'd1);
    chk("invalid_count", {30'd0, digit_count}, 32'd1);
    @(negedge clk);
    chk("invalid_one_cycle", {31'd0, invalid_digit}, 32'd0);
    @(posedge clk);
    #1;
    commit_expect(1, 8'd5, 1'b0, 1'b0, 4'd0);

`ifdef BCD_ACC_BACKSPACE_EN
    send_digit(4'd4); send_digit(4'd7); send_digit(4'hA);
    @(negedge clk);
    chk("bksp_count", {30'd0, digit_count}, 32'd1);
    chk("bksp_no_invalid", {31'd0, invalid_digit}, 32'd0);
    @(posedge clk);
    #1;
    commit_expect(1, 8'd4, 1'b0, 1'b0, 4'd0);
    send_digit(4'hA);
    @(negedge clk);
    chk("bksp_empty_count", {30'd0, digit_count}, 32'd0);
    chk("bksp_empty_invalid", {31'd0, invalid_digit}, 32'd0);
    @(posedge clk);
    #1;
    send_digit(4'd1); send_digit(4'd2); send_digit(4'd3); send_digit(4'hA);
    @(negedge clk);
    chk("bksp_full_count", {30'd0, digit_count}, 32'd2);
    @(posedge clk);
    #1;
    commit_expect(2, 8'd12, 1'b0, 1'b0, 4'd0);
`else
    send_digit(4'd6); send_digit(4'hA);
    @(negedge clk);
    chk("a_invalid_pulse", {31'd0, invalid_digit}, 32'd1);
    chk("a_invalid_count", {30'd0, digit_count}, 32'd1);
    @(posedge clk);
    #1;
    commit_expect(1, 8'd6, 1'b0, 1'b0, 4'd0);
`endif

    repeat (3) @(posedge clk);
    #1;
    chk("queue_drained", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
